mix_columns_engine: RTL and testbench
=====================================

MIX_COLUMNS_ENGINE -- requirements
Module: mix_columns_engine

Interface
REQ-001 Parameter NUM_COLS, default 4, number of 32-bit state columns per block (legal 1..8).
REQ-002 Parameter COLS_PER_CYCLE, default 1, columns mixed per clock (legal 1, 2, 4; NUM_COLS divisible by it).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  in_data/in_mode offered.
REQ-006 in_ready  output  1  engine accepts a block this cycle.
REQ-007 in_mode  input  1  0 = forward MixColumns, 1 = inverse MixColumns.
REQ-008 in_data  input  32*NUM_COLS  state; column c = bits [32c+31:32c], row r of a column = bits [8r+7:8r].
REQ-009 out_valid  output  1  out_data holds a finished block.
REQ-010 out_ready  input  1  consumer takes out_data.
REQ-011 out_data  output  32*NUM_COLS  mixed state, same layout as in_data.

Function
REQ-012 Arithmetic in GF(2^8), reduction polynomial 0x11b: xtime(x) = (x<<1) XOR (0x1b if x[7]), all products built from xtime and XOR, width 8 bits throughout.
REQ-013 Forward column: b_r = 2*a_r ^ 3*a_(r+1) ^ a_(r+2) ^ a_(r+3), indices mod 4.
REQ-014 Inverse column: b_r = 14*a_r ^ 11*a_(r+1) ^ 13*a_(r+2) ^ 9*a_(r+3), indices mod 4.
REQ-015 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-016 IDLE: in_ready=1; in_valid&in_ready latches in_data and in_mode, clears group counter, goes BUSY.
REQ-017 BUSY: in_ready=0; each cycle mixes columns [k*COLS_PER_CYCLE .. k*COLS_PER_CYCLE+COLS_PER_CYCLE-1] of the latched block in place, k = group counter, then increments k.
REQ-018 After group NUM_COLS/COLS_PER_CYCLE-1 is written, go DONE; out_valid rises the next cycle after that write.
REQ-019 Latency: acceptance at edge t gives out_valid=1 from edge t+NUM_COLS/COLS_PER_CYCLE.
REQ-020 DONE: out_valid=1, out_data stable until out_valid&out_ready.
REQ-021 DONE with out_ready=1: in_ready=1; simultaneous in_valid loads new block and goes BUSY (zero-bubble back-to-back); without in_valid goes IDLE.
REQ-022 DONE with out_ready=0: in_ready=0, state held indefinitely.
REQ-023 in_mode and in_data changes while BUSY or stalled in DONE have no effect; mode is per block, latched at acceptance.
REQ-024 out_data equals the working register; its contents outside DONE are don't-care to consumers.

Reset
REQ-025 rst_n low, at any time including mid-BUSY, immediately forces IDLE, group counter 0, working register 0, out_valid 0, in_ready 0 while asserted.
REQ-026 After rst_n deasserts, in_ready=1 from the first clock edge; the interrupted block is discarded, no partial output.

Structure
REQ-027 Package aes_pkg holds the 0x1b reduction constant, the mode encoding (MODE_FWD=0, MODE_INV=1) and the FSM state type.
REQ-028 One combinational sub-module mix_column (32-bit in, mode, 32-bit out) performs REQ-013/014; engine instantiates COLS_PER_CYCLE copies.
REQ-029 No inferred latches; column selection by counter via indexed part-select only.

Verification
REQ-030 Forward, NUM_COLS=4, COLS_PER_CYCLE=1: column 0x455313db -> 0xbca14d8e; 0x5c220af2 -> 0x9d58dc9f; 0x01010101 -> 0x01010101; 0xc6c6c6c6 -> 0xc6c6c6c6; out_valid exactly 4 cycles after acceptance.
REQ-031 Inverse of REQ-030 outputs returns original columns; forward-then-inverse of 1000 random blocks is identity, for COLS_PER_CYCLE 1, 2, 4 (latency 4, 2, 1).
REQ-032 Backpressure: out_ready held 0 for 10 cycles in DONE -> out_data/out_valid stable, in_ready=0; release with in_valid=1 -> next block accepted same edge.
REQ-033 rst_n pulsed low in 2nd BUSY cycle -> out_valid 0 immediately, in_ready 1 after release, next block 0x305dbfd4 (column) -> 0xe5816604 forward.
REQ-034 in_mode toggled during BUSY -> result matches mode latched at acceptance.

Source files
------------

// File: rtl/aes_pkg.sv
`timescale 1ns/1ps
// Shared GF(2^8) constants, mode encoding, FSM state type and column helpers for the MixColumns engine.
package aes_pkg;

   localparam int unsigned COL_W    = 32;
   localparam int unsigned BYTE_W   = 8;
   localparam logic [7:0]  GF_RED   = 8'h1b;

   typedef enum logic {
      MODE_FWD = 1'b0,
      MODE_INV = 1'b1
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // One state column; element r is row r, i.e. bits [8r+7:8r].
   typedef logic [3:0][7:0] col_t;

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? GF_RED : 8'h00);
   endfunction

endpackage

// File: rtl/mix_column.sv
`timescale 1ns/1ps
// Combinational forward/inverse MixColumns on one 32-bit column.
module mix_column
   import aes_pkg::*;
(
   input  logic [31:0] col_in,
   input  logic        mode,
   output logic [31:0] col_out
);

   col_t a;
   col_t x2;
   col_t x4;
   col_t x8;
   col_t fwd;
   col_t inv;

   assign a = col_t'(col_in);

   // Per-byte doublings; every coefficient below is an XOR of these.
   for (genvar j = 0; j < 4; j++) begin : g_xt
      assign x2[j] = xtime(a[j]);
      assign x4[j] = xtime(x2[j]);
      assign x8[j] = xtime(x4[j]);
   end

   // Row r mixes bytes r, r+1, r+2, r+3 (mod 4) with the circulant coefficients.
   for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int unsigned N1 = (r + 1) % 4;
      localparam int unsigned N2 = (r + 2) % 4;
      localparam int unsigned N3 = (r + 3) % 4;

      // 2*a_r ^ 3*a_r+1 ^ a_r+2 ^ a_r+3
      assign fwd[r] = x2[r] ^ (x2[N1] ^ a[N1]) ^ a[N2] ^ a[N3];

      // 14*a_r ^ 11*a_r+1 ^ 13*a_r+2 ^ 9*a_r+3
      assign inv[r] = (x8[r]  ^ x4[r]  ^ x2[r])
                    ^ (x8[N1] ^ x2[N1] ^ a[N1])
                    ^ (x8[N2] ^ x4[N2] ^ a[N2])
                    ^ (x8[N3] ^ a[N3]);
   end

   assign col_out = (mode == MODE_INV) ? 32'(inv) : 32'(fwd);

endmodule

// File: rtl/mix_columns_engine.sv
`timescale 1ns/1ps
// Block-level MixColumns engine: latches a block, mixes COLS_PER_CYCLE columns per cycle in place,
// then holds the result until the consumer takes it.
module mix_columns_engine
   import aes_pkg::*;
#(
   parameter int unsigned NUM_COLS       = 4,
   parameter int unsigned COLS_PER_CYCLE = 1
)
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      in_mode,
   input  logic [32*NUM_COLS-1:0]    in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [32*NUM_COLS-1:0]    out_data
);

   localparam int unsigned DATA_W     = COL_W * NUM_COLS;
   localparam int unsigned GROUP_W    = COL_W * COLS_PER_CYCLE;
   localparam int unsigned NUM_GROUPS = NUM_COLS / COLS_PER_CYCLE;
   localparam int unsigned GRP_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
   localparam int unsigned IDX_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NUM_GROUPS - 1);

   state_e              state_q;
   state_e              state_d;
   logic [GRP_W-1:0]    grp_q;
   logic [GRP_W-1:0]    grp_d;
   logic [DATA_W-1:0]   work_q;
   logic [DATA_W-1:0]   work_d;
   logic                mode_q;
   logic                mode_d;
   logic                alive_q;
   logic                load_c;
   logic [IDX_W-1:0]    base_c;
   logic [GROUP_W-1:0]  grp_in_c;
   logic [GROUP_W-1:0]  grp_out_c;

   // Bit offset of the column group selected by the counter.
   assign base_c   = IDX_W'(32'(grp_q) * GROUP_W);
   assign grp_in_c = work_q[base_c +: GROUP_W];

   // One mixer per column processed in a cycle, all sharing the latched mode.
   for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_mix
      mix_column u_mix_column (
         .col_in  (grp_in_c[i*COL_W +: COL_W]),
         .mode    (mode_q),
         .col_out (grp_out_c[i*COL_W +: COL_W])
      );
   end

   // Handshake: ready only once a clock edge has been seen out of reset.
   assign in_ready  = alive_q & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));
   assign load_c    = in_valid & in_ready;
   assign out_valid = (state_q == ST_DONE);
   assign out_data  = work_q;

   // Marks the first clock edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alive_q <= 1'b0;
      end else begin
         alive_q <= 1'b1;
      end
   end

   // State, group counter, working block and latched mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         grp_q   <= '0;
         work_q  <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grp_q   <= grp_d;
         work_q  <= work_d;
         mode_q  <= mode_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      grp_d   = grp_q;
      work_d  = work_q;
      mode_d  = mode_q;

      case (state_q)
         ST_IDLE: begin
            if (load_c) begin
               state_d = ST_BUSY;
               grp_d   = '0;
               work_d  = in_data;
               mode_d  = in_mode;
            end
         end

         ST_BUSY: begin
            work_d[base_c +: GROUP_W] = grp_out_c;
            grp_d = grp_q + GRP_W'(1);
            if (grp_q == LAST_GRP) begin
               state_d = ST_DONE;
               grp_d   = '0;
            end
         end

         ST_DONE: begin
            if (out_ready) begin
               if (load_c) begin
                  state_d = ST_BUSY;
                  grp_d   = '0;
                  work_d  = in_data;
                  mode_d  = in_mode;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mix_columns_engine.sv
`timescale 1ns/1ps
// Self-checking bench: three engines (1, 2, 4 columns per cycle) against a GF(2^8) matrix model.
module tb_mix_columns_engine;

   localparam int unsigned NC      = 4;
   localparam int unsigned DW      = 32 * NC;
   localparam int          NDUT    = 3;
   localparam int          TIMEOUT = 50;

   typedef struct {
      bit            mode;
      logic [DW-1:0] din;
      logic [DW-1:0] exp;
   } vec_t;

   logic          clk;
   logic          rst_n;
   logic          in_valid  [NDUT];
   logic          in_ready  [NDUT];
   logic          in_mode   [NDUT];
   logic [DW-1:0] in_data   [NDUT];
   logic          out_valid [NDUT];
   logic          out_ready [NDUT];
   logic [DW-1:0] out_data  [NDUT];

   int errors;
   int checks;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      mix_columns_engine #(
         .NUM_COLS       (NC),
         .COLS_PER_CYCLE (1 << g)
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_mode   (in_mode[g]),
         .in_data   (in_data[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .out_data  (out_data[g])
      );
   end

   // Carry-less product followed by long division by 0x11b.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'h0000;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ (16'(a) << i);
      end
      for (int i = 14; i >= 8; i--) begin
         if (p[i]) p = p ^ (16'h011b << (i - 8));
      end
      return p[7:0];
   endfunction

   // Circulant matrix times each column of the block.
   function automatic logic [DW-1:0] ref_mix(input logic [DW-1:0] din, input bit inv);
      logic [7:0]    coef [4];
      logic [7:0]    acc;
      logic [DW-1:0] res;
      if (inv) begin
         coef[0] = 8'd14; coef[1] = 8'd11; coef[2] = 8'd13; coef[3] = 8'd9;
      end else begin
         coef[0] = 8'd2;  coef[1] = 8'd3;  coef[2] = 8'd1;  coef[3] = 8'd1;
      end
      res = '0;
      for (int c = 0; c < int'(NC); c++) begin
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) begin
               acc = acc ^ gf_mul(coef[j], din[32*c + 8*((r + j) % 4) +: 8]);
            end
            res[32*c + 8*r +: 8] = acc;
         end
      end
      return res;
   endfunction

   function automatic logic [DW-1:0] rand_block();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Offer a block and return on the falling edge just after it is accepted.
   task automatic send(input int g, input bit m, input logic [DW-1:0] d);
      int n;
      @(negedge clk);
      in_valid[g] = 1'b1;
      in_mode[g]  = m;
      in_data[g]  = d;
      n = 0;
      while (in_ready[g] !== 1'b1 && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      if (n >= TIMEOUT) begin
         checks++;
         errors++;
         $display("FAIL send_timeout dut%0d: in_ready never rose within %0d cycles", g, TIMEOUT);
      end
      @(negedge clk);
      in_valid[g] = 1'b0;
   endtask

   // Wait for out_valid; lat counts edges since the accepting edge.
   task automatic recv(input int g, output logic [DW-1:0] d, output int lat);
      int n;
      out_ready[g] = 1'b1;
      n = 0;
      while (out_valid[g] !== 1'b1 && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      if (n >= TIMEOUT) begin
         checks++;
         errors++;
         $display("FAIL recv_timeout dut%0d: out_valid never rose within %0d cycles", g, TIMEOUT);
      end
      d   = out_data[g];
      lat = n;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t          tbl [4];
      logic [DW-1:0] d;
      logic [DW-1:0] d2;
      logic [DW-1:0] r;
      logic [DW-1:0] b;
      logic [DW-1:0] held;
      int            lat;
      int            n;
      bit            m;

      errors = 0;
      checks = 0;

      tbl[0].mode = 1'b0;
      tbl[0].din  = {32'hc6c6c6c6, 32'h01010101, 32'h5c220af2, 32'h455313db};
      tbl[0].exp  = {32'hc6c6c6c6, 32'h01010101, 32'h9d58dc9f, 32'hbca14d8e};
      tbl[1].mode = 1'b1;
      tbl[1].din  = tbl[0].exp;
      tbl[1].exp  = tbl[0].din;
      tbl[2].mode = 1'b0;
      tbl[2].din  = {32'h305dbfd4, 32'h455313db, 32'h01010101, 32'h5c220af2};
      tbl[2].exp  = {32'he5816604, 32'hbca14d8e, 32'h01010101, 32'h9d58dc9f};
      tbl[3].mode = 1'b1;
      tbl[3].din  = tbl[2].exp;
      tbl[3].exp  = tbl[2].din;

      rst_n = 1'b0;
      for (int g = 0; g < NDUT; g++) begin
         in_valid[g]  = 1'b0;
         in_mode[g]   = 1'b0;
         in_data[g]   = '0;
         out_ready[g] = 1'b1;
      end

      // Reset values while rst_n is held low.
      repeat (3) @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
         check($sformatf("rst_in_ready%0d", g),  DW'(in_ready[g]),  '0);
         check($sformatf("rst_out_valid%0d", g), DW'(out_valid[g]), '0);
         check($sformatf("rst_out_data%0d", g),  out_data[g],       '0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
         check($sformatf("post_rst_in_ready%0d", g), DW'(in_ready[g]), DW'(1));
      end

      // Known vectors through every throughput configuration.
      for (int g = 0; g < NDUT; g++) begin
         for (int k = 0; k < 4; k++) begin
            send(g, tbl[k].mode, tbl[k].din);
            recv(g, r, lat);
            check($sformatf("tbl%0d_dut%0d_data", k, g), r, tbl[k].exp);
            check($sformatf("tbl%0d_dut%0d_lat", k, g), DW'(lat), DW'(4 >> g));
         end
      end

      // Random blocks: mix in a random direction, then undo with the other.
      for (int g = 0; g < NDUT; g++) begin
         for (int k = 0; k < 1000; k++) begin
            d = rand_block();
            m = 1'($urandom_range(1, 0));
            send(g, m, d);
            recv(g, r, lat);
            check($sformatf("rnd_dut%0d_mix", g), r, ref_mix(d, m));
            send(g, !m, r);
            recv(g, b, lat);
            check($sformatf("rnd_dut%0d_roundtrip", g), b, d);
         end
      end

      // Backpressure: stall 10 cycles in DONE with junk on the inputs, then release with a new block.
      d = rand_block();
      out_ready[0] = 1'b0;
      send(0, 1'b0, d);
      n = 0;
      while (out_valid[0] !== 1'b1 && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      held = out_data[0];
      check("bp_result", held, ref_mix(d, 1'b0));
      in_valid[0] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data[0] = rand_block();
         in_mode[0] = ~in_mode[0];
         @(negedge clk);
         check("bp_out_valid", DW'(out_valid[0]), DW'(1));
         check("bp_out_data",  out_data[0],       held);
         check("bp_in_ready",  DW'(in_ready[0]),  '0);
      end
      d2 = rand_block();
      in_data[0]   = d2;
      in_mode[0]   = 1'b0;
      out_ready[0] = 1'b1;
      #1;
      check("bp_release_in_ready", DW'(in_ready[0]), DW'(1));
      @(negedge clk);
      in_valid[0] = 1'b0;
      check("bp_next_busy_out_valid", DW'(out_valid[0]), '0);
      check("bp_next_busy_in_ready",  DW'(in_ready[0]),  '0);
      recv(0, r, lat);
      check("bp_next_data", r, ref_mix(d2, 1'b0));
      check("bp_next_lat",  DW'(lat), DW'(4));

      // Reset pulsed during the second BUSY cycle.
      send(0, 1'b0, rand_block());
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", DW'(out_valid[0]), '0);
      check("midrst_in_ready",  DW'(in_ready[0]),  '0);
      check("midrst_out_data",  out_data[0],       '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_release_in_ready",  DW'(in_ready[0]),  DW'(1));
      check("midrst_release_out_valid", DW'(out_valid[0]), '0);
      send(0, 1'b0, {4{32'h305dbfd4}});
      recv(0, r, lat);
      check("midrst_next_data", r, {4{32'he5816604}});
      check("midrst_next_lat",  DW'(lat), DW'(4));

      // Mode and data wiggled while BUSY must not alter the latched block.
      d = rand_block();
      send(0, 1'b1, d);
      for (int i = 0; i < 3; i++) begin
         in_mode[0] = ~in_mode[0];
         in_data[0] = rand_block();
         @(negedge clk);
      end
      recv(0, r, lat);
      check("mode_latched_data", r, ref_mix(d, 1'b1));

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
